// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with a registered fill count, programmable almost-full/almost-empty levels,
// registered overflow/underflow pulses and an optional show-ahead (asynchronous head) read port.
module sync_fifo_core #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR      = 4,
  parameter int unsigned SHOWAHEAD = 0,
  parameter int unsigned AF_LEVEL  = 12,
  parameter int unsigned AE_LEVEL  = 2
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] di,
  input  logic             rdreq,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDR:0]    usedw,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned   DEPTH   = 1 << ADDR;
  localparam logic [ADDR:0] DEPTH_W = (ADDR + 1)'(DEPTH);
  localparam logic [ADDR:0] AF_W    = (ADDR + 1)'(AF_LEVEL);
  localparam logic [ADDR:0] AE_W    = (ADDR + 1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR-1:0]  wr_ptr_q;
  logic [ADDR-1:0]  rd_ptr_q;
  logic [ADDR:0]    usedw_q;
  logic             ovf_q;
  logic             unf_q;
  logic             wr_acc;
  logic             rd_acc;

  // Flags decode the registered count, so no pass-through at full and no fall-through at empty.
  assign full         = (usedw_q == DEPTH_W);
  assign empty        = (usedw_q == '0);
  assign almost_full  = (usedw_q >= AF_W);
  assign almost_empty = (usedw_q <= AE_W);
  assign usedw        = usedw_q;
  assign ovf          = ovf_q;
  assign unf          = unf_q;

  assign wr_acc = wrreq & ~full;
  assign rd_acc = rdreq & ~empty;

  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   usedw_q <= usedw_q + 1'b1;
        2'b01:   usedw_q <= usedw_q - 1'b1;
        default: usedw_q <= usedw_q;
      endcase
      ovf_q <= wrreq & full;
      unf_q <= rdreq & empty;
    end
  end

  // Storage is never cleared; sclr only blocks the write in its own cycle.
  always_ff @(posedge clk) begin
    if (wr_acc && !sclr) mem[wr_ptr_q] <= di;
  end

  if (SHOWAHEAD != 0) begin : g_showahead
    assign dout = mem[rd_ptr_q];
  end else begin : g_normal
    logic [WIDTH-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (sclr)        dout_q <= '0;
      else if (rd_acc) dout_q <= mem[rd_ptr_q];
    end
    assign dout = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_core.sv
// Randomised scoreboard bench for sync_fifo_core: a normal-read instance and a show-ahead
// instance, each checked against a queue-based reference model.
module tb_sync_fifo_core;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic        clk = 1'b0;
  logic        sclr, wrreq, rdreq;
  logic [15:0] di, dout;
  logic        full, empty, almost_full, almost_empty, ovf, unf;
  logic [4:0]  usedw;

  logic        sa_sclr, sa_wrreq, sa_rdreq;
  logic [15:0] sa_di, sa_dout;
  logic        sa_full, sa_empty, sa_af, sa_ae, sa_ovf, sa_unf;
  logic [4:0]  sa_usedw;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sync_fifo_core u_dut (
    .clk(clk), .sclr(sclr), .wrreq(wrreq), .di(di), .rdreq(rdreq), .dout(dout),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .usedw(usedw), .ovf(ovf), .unf(unf)
  );

  sync_fifo_core #(.SHOWAHEAD(1)) u_sa (
    .clk(clk), .sclr(sa_sclr), .wrreq(sa_wrreq), .di(sa_di), .rdreq(sa_rdreq), .dout(sa_dout),
    .full(sa_full), .empty(sa_empty), .almost_full(sa_af), .almost_empty(sa_ae),
    .usedw(sa_usedw), .ovf(sa_ovf), .unf(sa_unf)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue, updated at each edge from the driven requests.
  logic [15:0] mq[$];
  logic [15:0] exp_q[$];
  bit          en, rd_evt, rst_evt, e_ovf, e_unf;

  always @(posedge clk) begin
    bit f, e;
    rd_evt  = 0;
    rst_evt = 0;
    if (sclr) begin
      mq.delete();
      e_ovf   = 0;
      e_unf   = 0;
      rst_evt = 1;
      en      = 1;
    end else begin
      f     = (mq.size() == DEPTH);
      e     = (mq.size() == 0);
      e_ovf = wrreq && f;
      e_unf = rdreq && e;
      if (rdreq && !e) begin
        exp_q.push_back(mq.pop_front());
        rd_evt = 1;
      end
      if (wrreq && !f) mq.push_back(di);
    end
  end

  // Monitor: pops the scoreboard when the DUT presents read data, checks everything else.
  logic [15:0] last_do;
  always @(negedge clk) begin
    if (en) begin
      if (rst_evt) begin
        exp_q.delete();
        last_do = 16'h0;
      end
      if (rd_evt) begin
        if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
        else last_do = exp_q.pop_front();
      end
      chk("dout", dout, last_do);
      chk("usedw", usedw, mq.size());
      chk("full", full, mq.size() == DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("almost_full", almost_full, mq.size() >= AF);
      chk("almost_empty", almost_empty, mq.size() <= AE);
      chk("ovf", ovf, e_ovf);
      chk("unf", unf, e_unf);
    end
  end

  // Show-ahead model and monitor: head word must be visible whenever not empty.
  logic [15:0] sq[$];
  bit          sa_en;

  always @(posedge clk) begin
    bit f, e;
    if (sa_sclr) begin
      sq.delete();
      sa_en = 1;
    end else begin
      f = (sq.size() == DEPTH);
      e = (sq.size() == 0);
      if (sa_rdreq && !e) void'(sq.pop_front());
      if (sa_wrreq && !f) sq.push_back(sa_di);
    end
  end

  always @(negedge clk) begin
    if (sa_en) begin
      chk("sa_usedw", sa_usedw, sq.size());
      chk("sa_empty", sa_empty, sq.size() == 0);
      if (sq.size() != 0) chk("sa_dout", sa_dout, sq[0]);
    end
  end

  task automatic step(input bit w, input logic [15:0] d, input bit r, input bit s);
    wrreq = w;
    di    = d;
    rdreq = r;
    sclr  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 0, 0);
  endtask

  initial begin
    sclr = 0; wrreq = 0; rdreq = 0; di = 0;
    sa_sclr = 1; sa_wrreq = 0; sa_rdreq = 0; sa_di = 0;

    // Reset for two cycles, then idle.
    step(0, 16'h0, 0, 1);
    step(0, 16'h0, 0, 1);
    sa_sclr = 0;
    idle(2);

    // Fill, then one write while full.
    for (int i = 0; i < DEPTH; i++) step(1, 16'h1000 + 16'(i), 0, 0);
    step(1, 16'hDEAD, 0, 0);
    idle(2);

    // Drain, then one read while empty.
    for (int i = 0; i <= DEPTH; i++) step(0, 16'h0, 1, 0);
    idle(2);

    // Hold usedw at 5 with simultaneous traffic; pointers wrap.
    for (int i = 0; i < 5; i++) step(1, 16'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) step(1, 16'($urandom), 1, 0);
    idle(1);

    // Reset colliding with requests at usedw=10.
    for (int i = 0; i < 5; i++) step(1, 16'($urandom), 0, 0);
    step(1, 16'hBEEF, 1, 1);
    step(1, 16'h5A5A, 0, 0);
    idle(1);
    step(0, 16'h0, 1, 0);
    idle(2);

    // Show-ahead: word visible without rdreq, then pop.
    sa_wrreq = 1; sa_di = 16'hA5A5;
    @(posedge clk); #1;
    sa_wrreq = 0;
    @(posedge clk); #1;
    sa_rdreq = 1;
    @(posedge clk); #1;
    sa_rdreq = 0;
    idle(1);

    // Random traffic on both instances, with occasional resets.
    for (int i = 0; i < 300; i++) begin
      sa_wrreq = ($urandom_range(0, 99) < 55);
      sa_rdreq = ($urandom_range(0, 99) < 45);
      sa_di    = 16'($urandom);
      sa_sclr  = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 99) < (i < 150 ? 65 : 35), 16'($urandom),
           $urandom_range(0, 99) < (i < 150 ? 35 : 65), $urandom_range(0, 99) == 0);
    end
    sa_wrreq = 0; sa_rdreq = 0; sa_sclr = 0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
